// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron trainer: weight width, FSM states and
// the saturating add/subtract applied to weights.
package perceptron_pkg;

  localparam int WEIGHT_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    UPDATE
  } state_t;

  // Works in 33 bits so overflow shows up as a disagreement between the top two bits.
  function automatic logic [WEIGHT_W-1:0] sat_add(
    input logic [WEIGHT_W-1:0] a,
    input logic [WEIGHT_W-1:0] b,
    input logic                sub
  );
    logic [WEIGHT_W:0] r;
    if (sub) r = {a[WEIGHT_W-1], a} - {b[WEIGHT_W-1], b};
    else     r = {a[WEIGHT_W-1], a} + {b[WEIGHT_W-1], b};
    if (r[WEIGHT_W] != r[WEIGHT_W-1])
      return r[WEIGHT_W] ? {1'b1, {(WEIGHT_W-1){1'b0}}} : {1'b0, {(WEIGHT_W-1){1'b1}}};
    return r[WEIGHT_W-1:0];
  endfunction

endpackage

// File: rtl/perceptron_trainer_weight_update_unit.sv
// Next value for the one weight selected in UPDATE: +/- RATE with saturation,
// or unchanged when its input bit is clear.
module weight_update_unit
  import perceptron_pkg::*;
#(
  parameter int RATE = 1
) (
  input  logic [WEIGHT_W-1:0] w_cur,
  input  logic                en,
  input  logic                inc,
  output logic [WEIGHT_W-1:0] w_next
);

  localparam logic [WEIGHT_W-1:0] STEP = RATE;

  always_comb begin
    w_next = w_cur;
    if (en) w_next = sat_add(w_cur, STEP, !inc);
  end

endmodule

// File: rtl/perceptron_trainer.sv
// Single-layer perceptron trainer: owns the weights, thresholds the returned
// sum and applies the learning rule one weight per cycle on a mismatch.
module perceptron_trainer
  import perceptron_pkg::*;
#(
  parameter int N      = 8,
  parameter int RATE   = 1,
  parameter int THRESH = 1,
  parameter int W_INIT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  input  logic [N-1:0]          x_in,
  input  logic                  target,
  input  logic                  learn_en,
  output logic [N-1:0]          x_q,
  output logic [WEIGHT_W*N-1:0] w,
  input  logic [WEIGHT_W-1:0]   sum,
  output logic                  y,
  output logic                  y_valid,
  output logic                  done,
  output logic [15:0]           err_count
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  state_t              state;
  logic [WEIGHT_W-1:0] weights [N];
  logic [IDX_W-1:0]    idx;
  logic                target_q;
  logic                learn_q;
  logic                y_new;
  logic [WEIGHT_W-1:0] w_next;

  assign sample_ready = (state == IDLE);
  assign y_new        = ($signed(sum) >= THRESH);

  for (genvar g = 0; g < N; g++) begin : g_wbus
    assign w[WEIGHT_W*g +: WEIGHT_W] = weights[g];
  end

  weight_update_unit #(
    .RATE(RATE)
  ) u_update (
    .w_cur (weights[idx]),
    .en    (x_q[idx]),
    .inc   (target_q),
    .w_next(w_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      for (int unsigned i = 0; i < N; i++) weights[i] <= W_INIT;
      idx       <= '0;
      x_q       <= '0;
      target_q  <= 1'b0;
      learn_q   <= 1'b0;
      y         <= 1'b0;
      y_valid   <= 1'b0;
      done      <= 1'b0;
      err_count <= '0;
    end else begin
      y_valid <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_valid) begin
            x_q      <= x_in;
            target_q <= target;
            learn_q  <= learn_en;
            state    <= EVAL;
          end
        end
        EVAL: begin
          y       <= y_new;
          y_valid <= 1'b1;
          if (y_new == target_q) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            if (err_count != '1) err_count <= err_count + 16'd1;
            if (learn_q) begin
              idx   <= '0;
              state <= UPDATE;
            end else begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        UPDATE: begin
          weights[idx] <= w_next;
          if (idx == IDX_W'(N - 1)) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Bench for perceptron_trainer: per-sample behavioural model plus directed
// saturation and mid-update reset scenarios on a second instance.
module tb_perceptron_trainer;

  localparam int N = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           a_rst_n, a_valid, a_ready, a_target, a_learn, a_y, a_yv, a_done;
  logic [N-1:0]   a_x, a_xq;
  logic [32*N-1:0] a_w;
  logic [31:0]    a_sum;
  logic [15:0]    a_err;

  logic           b_rst_n, b_valid, b_ready, b_target, b_learn, b_y, b_yv, b_done;
  logic [N-1:0]   b_x, b_xq;
  logic [32*N-1:0] b_w;
  logic [31:0]    b_sum;
  logic [15:0]    b_err;

  perceptron_trainer #(.N(N)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .sample_valid(a_valid), .sample_ready(a_ready),
    .x_in(a_x), .target(a_target), .learn_en(a_learn), .x_q(a_xq), .w(a_w),
    .sum(a_sum), .y(a_y), .y_valid(a_yv), .done(a_done), .err_count(a_err)
  );

  perceptron_trainer #(.N(N), .W_INIT(32'h7FFFFFFF)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .sample_valid(b_valid), .sample_ready(b_ready),
    .x_in(b_x), .target(b_target), .learn_en(b_learn), .x_q(b_xq), .w(b_w),
    .sum(b_sum), .y(b_y), .y_valid(b_yv), .done(b_done), .err_count(b_err)
  );

  // Stand-in for weighted_sum feeding instance A.
  always_comb begin
    a_sum = '0;
    for (int i = 0; i < N; i++)
      if (a_xq[i]) a_sum = a_sum + a_w[32*i +: 32];
  end

  int n_err = 0;
  int n_chk = 0;

  longint       mw [N];
  logic         check_en = 1'b0;
  logic         check_w = 1'b1;
  logic         exp_ready, exp_yv, exp_done, exp_y;
  logic [N-1:0] exp_xq;
  logic [15:0]  exp_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic model_y(input logic [N-1:0] x);
    longint s = 0;
    for (int i = 0; i < N; i++) if (x[i]) s += mw[i];
    return int'(s) >= 1;
  endfunction

  task automatic model_learn(input logic [N-1:0] x, input logic t);
    for (int i = 0; i < N; i++) begin
      if (x[i]) begin
        mw[i] = mw[i] + (t ? 1 : -1);
        if (mw[i] > 64'sd2147483647)  mw[i] = 64'sd2147483647;
        if (mw[i] < -64'sd2147483648) mw[i] = -64'sd2147483648;
      end
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("sample_ready", a_ready, exp_ready);
      chk("y_valid", a_yv, exp_yv);
      chk("done", a_done, exp_done);
      chk("y", a_y, exp_y);
      chk("err_count", a_err, exp_err);
      chk("x_q", a_xq, exp_xq);
      if (check_w)
        for (int i = 0; i < N; i++)
          chk($sformatf("w%0d", i), a_w[32*i +: 32], mw[i][31:0]);
    end
  end

  task automatic idle_cycle();
    @(posedge clk); #1;
    a_valid = 1'b0;
    exp_yv = 1'b0; exp_done = 1'b0; exp_ready = 1'b1;
  endtask

  task automatic run_sample(input logic [N-1:0] x, input logic t, input logic l);
    logic ym;
    logic upd;
    @(posedge clk); #1;
    a_valid = 1'b1; a_x = x; a_target = t; a_learn = l;
    exp_ready = 1'b1; exp_yv = 1'b0; exp_done = 1'b0; check_w = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'($urandom_range(0, 1)); a_x = N'($urandom);
    a_target = 1'($urandom_range(0, 1)); a_learn = 1'($urandom_range(0, 1));
    exp_ready = 1'b0; exp_xq = x;
    ym  = model_y(x);
    upd = (ym != t) && l;
    @(posedge clk); #1;
    exp_yv = 1'b1; exp_y = ym;
    if (ym != t && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
    if (upd) begin
      a_valid = 1'($urandom_range(0, 1));
      check_w = 1'b0; exp_done = 1'b0; exp_ready = 1'b0;
      for (int k = 1; k < N; k++) begin
        @(posedge clk); #1;
        exp_yv = 1'b0;
        a_valid = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      model_learn(x, t);
      check_w = 1'b1; exp_yv = 1'b0;
    end
    a_valid = 1'b0; exp_done = 1'b1; exp_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic yy;
    bit   seen;
    a_rst_n = 1'b1; a_valid = 1'b0; a_x = '0; a_target = 1'b0; a_learn = 1'b0;
    b_rst_n = 1'b0; b_valid = 1'b0; b_x = '0; b_target = 1'b0; b_learn = 1'b0;
    b_sum = '0;
    for (int i = 0; i < N; i++) mw[i] = 0;
    exp_ready = 1'b1; exp_yv = 1'b0; exp_done = 1'b0; exp_y = 1'b0;
    exp_xq = '0; exp_err = '0;

    #2 a_rst_n = 1'b0;
    #1;
    chk("rst_w", a_w, '0);
    chk("rst_y", a_y, 0);
    chk("rst_y_valid", a_yv, 0);
    chk("rst_done", a_done, 0);
    chk("rst_err", a_err, 0);
    #10 a_rst_n = 1'b1;
    chk("rst_ready", a_ready, 1);
    check_en = 1'b1;
    idle_cycle();

    run_sample(8'h05, 1'b1, 1'b1);
    chk("t2_w0", a_w[31:0], 1);
    chk("t2_w1", a_w[63:32], 0);
    chk("t2_w2", a_w[95:64], 1);
    chk("t2_y", a_y, 0);
    chk("t2_err", a_err, 1);

    run_sample(8'h05, 1'b1, 1'b1);
    chk("t3_y", a_y, 1);
    chk("t3_w0", a_w[31:0], 1);
    chk("t3_err", a_err, 1);

    run_sample(8'h05, 1'b0, 1'b1);
    chk("t4_w0", a_w[31:0], 0);
    chk("t4_w2", a_w[95:64], 0);
    chk("t4_err", a_err, 2);

    run_sample(8'h03, 1'b1, 1'b0);
    chk("t5_y", a_y, 0);
    chk("t5_err", a_err, 3);
    chk("t5_w", a_w, '0);

    for (int it = 0; it < 40; it++) begin
      run_sample(N'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

    // Mid-update reset on A: weights must fall straight back to zero.
    check_en = 1'b0;
    yy = model_y('1);
    @(posedge clk); #1;
    a_valid = 1'b1; a_x = '1; a_target = !yy; a_learn = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 a_rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", a_ready, 0 == 0);
    chk("mid_rst_w", a_w, '0);
    chk("mid_rst_err", a_err, 0);
    chk("mid_rst_y", a_y, 0);
    chk("mid_rst_done", a_done, 0);

    // Instance B: weights start at the positive limit.
    @(posedge clk); #3 b_rst_n = 1'b1;
    @(posedge clk); #1;
    b_sum = 32'hFFFFFFFF;
    b_valid = 1'b1; b_x = 8'h01; b_target = 1'b1; b_learn = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (b_done) seen = 1;
    end
    chk("b_done_seen", seen, 1);
    chk("b_y", b_y, 0);
    chk("b_err", b_err, 1);
    chk("b_w0_sat", b_w[31:0], 32'h7FFFFFFF);

    b_sum = 32'd5;
    @(posedge clk); #1;
    b_valid = 1'b1; b_x = 8'hFF; b_target = 1'b0; b_learn = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("b_pre_w1", b_w[63:32], 32'h7FFFFFFE);
    chk("b_pre_w3", b_w[127:96], 32'h7FFFFFFF);
    chk("b_pre_ready", b_ready, 0);
    b_rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++)
      chk($sformatf("b_rst_w%0d", i), b_w[32*i +: 32], 32'h7FFFFFFF);
    chk("b_rst_ready", b_ready, 1);
    chk("b_rst_err", b_err, 0);
    chk("b_rst_done", b_done, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
